// File: rtl/seg_scan_driver_pkg.sv
// Shared 7-segment display constants: active-low glyphs {g,f,e,d,c,b,a} and digit positions.
// Reused by the timer preset path and any later display blocks.
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int NUM_DIGITS = 3;

  // Digit positions, rightmost first; the scan visits them in this order.
  typedef enum logic [1:0] {
    DIG_TENTHS = 2'd0,
    DIG_ONES   = 2'd1,
    DIG_TENS   = 2'd2
  } dig_idx_e;

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decode; 10..14 render a dash, 15 is blank.
module seg_scan_driver_bcd_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd15:   seg = SEG_BLANK;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed common-anode display driver with anti-ghost guard,
// per-frame input snapshot, leading-zero blanking and blink gating; all pins registered.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int GUARD_CYC = 16,
  parameter int BLINK_HZ  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] xiaoshu,
  input  logic       point,
  input  logic       led,
  input  logic       lzb,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int DIV       = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / BLINK_HZ;
  localparam int PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          run;
  dig_idx_e      idx, idx_nxt;

  logic [3:0]    sh_tens, sh_ones, sh_tenths;
  logic          sh_point, sh_led, sh_lzb;

  logic          slot_end, snap, blink_off, blank_tens;
  logic [3:0]    cur_bcd;
  logic [6:0]    dec_seg;
  logic [2:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d, frame_d;

  assign slot_end = (presc == PW'(DIV - 1));
  // A fresh frame starts either on the first enabled cycle or when the tens slot finishes.
  assign snap     = en && (!run || (slot_end && idx == DIG_TENS));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= DIG_TENTHS;
    end else begin
      idx <= idx_nxt;
    end
  end

  always_comb begin
    idx_nxt = idx;
    if (!en) begin
      idx_nxt = DIG_TENTHS;
    end else if (run && slot_end) begin
      case (idx)
        DIG_TENTHS: idx_nxt = DIG_ONES;
        DIG_ONES:   idx_nxt = DIG_TENS;
        default:    idx_nxt = DIG_TENTHS;
      endcase
    end
  end

  // The first enabled cycle only loads the snapshot; slot 0 begins on the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      run   <= 1'b0;
    end else if (!en) begin
      presc <= '0;
      run   <= 1'b0;
    end else if (!run) begin
      run   <= 1'b1;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= (blink_cnt == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_tens   <= '0;
      sh_ones   <= '0;
      sh_tenths <= '0;
      sh_point  <= 1'b0;
      sh_led    <= 1'b0;
      sh_lzb    <= 1'b0;
    end else if (snap) begin
      sh_tens   <= tens;
      sh_ones   <= ones;
      sh_tenths <= xiaoshu;
      sh_point  <= point;
      sh_led    <= led;
      sh_lzb    <= lzb;
    end
  end

  always_comb begin
    cur_bcd = sh_tenths;
    case (idx)
      DIG_ONES: cur_bcd = sh_ones;
      DIG_TENS: cur_bcd = sh_tens;
      default:  cur_bcd = sh_tenths;
    endcase
  end

  seg_scan_driver_bcd_to_seg u_bcd_to_seg (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  assign blank_tens = (idx == DIG_TENS) && sh_lzb && (sh_tens == 4'd0);
  assign blink_off  = sh_led && (blink_cnt >= BW'(BLINK_DIV / 2));

  // Segments follow the digit index, so they settle during the guard before the anode lights.
  always_comb begin
    an_d    = 3'b111;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    frame_d = snap;
    if (en && run) begin
      if (presc >= PW'(GUARD_CYC)) begin
        an_d = ~(3'b001 << idx);
      end
      if (!blank_tens && !blink_off) begin
        seg_d = dec_seg;
      end
      dp_d = !((idx == DIG_ONES) && sh_point && !blink_off);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= 3'b111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      an    <= an_d;
      seg   <= seg_d;
      dp    <= dp_d;
      frame <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver at DIV=10, GUARD=2, BLINK_DIV=100 against a frame-position model.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] tens = 4'd0, ones = 4'd0, xiaoshu = 4'd0;
  logic       point = 1'b0, led = 1'b0, lzb = 1'b0;
  logic [2:0] an;
  logic [6:0] seg;
  logic       dp, frame;

  int errors = 0;
  int checks = 0;

  // Model: m counts enabled edges since enable/reset (1 = snapshot edge),
  // bc is time since reset modulo the blink period.
  int         m = 0;
  int         bc = 0;
  logic [3:0] s_tens = 0, s_ones = 0, s_tenths = 0;
  logic       s_point = 0, s_led = 0, s_lzb = 0;
  logic [11:0] exp_pins;

  seg_scan_driver #(
    .CLK_HZ(1000), .SCAN_HZ(100), .GUARD_CYC(2), .BLINK_HZ(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tens(tens), .ones(ones), .xiaoshu(xiaoshu),
    .point(point), .led(led), .lzb(lzb), .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
      4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
      4'd8: return 7'h00;  4'd9: return 7'h10;  4'd15: return 7'h7F;
      default: return 7'h3F;
    endcase
  endfunction

  // One clock: predict the pins the edge produces, then sample them at the falling edge.
  task automatic tick();
    int pos, slot, off;
    logic [6:0] g;
    logic [3:0] d;
    logic [2:0] a;
    logic dpx;
    @(posedge clk);
    if (rst) begin
      m = 0; bc = 0;
      s_tens = 0; s_ones = 0; s_tenths = 0; s_point = 0; s_led = 0; s_lzb = 0;
      exp_pins = {3'b111, 7'h7F, 1'b1, 1'b0};
    end else begin
      m = en ? m + 1 : 0;
      if (m <= 1) begin
        exp_pins = {3'b111, 7'h7F, 1'b1, (m == 1)};
      end else begin
        pos = (m - 2) % 30; slot = pos / 10; off = pos % 10;
        a = (off < 2) ? 3'b111 : (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
        d = (slot == 0) ? s_tenths : (slot == 1) ? s_ones : s_tens;
        g = glyph(d);
        if (slot == 2 && s_lzb && s_tens == 4'd0) g = 7'h7F;
        dpx = !(slot == 1 && s_point);
        if (s_led && bc >= 50) begin g = 7'h7F; dpx = 1'b1; end
        exp_pins = {a, g, dpx, ((m - 1) % 30 == 0)};
      end
      if (m >= 1 && (m - 1) % 30 == 0) begin
        s_tens = tens; s_ones = ones; s_tenths = xiaoshu;
        s_point = point; s_led = led; s_lzb = lzb;
      end
      bc = (bc + 1) % 100;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({an, seg, dp, frame} !== 12'({3'b111, 7'h7F, 1'b1, 1'b0})) begin
        errors++; $display("FAIL reset got=%h exp=%h", {an, seg, dp, frame}, {3'b111, 7'h7F, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_basic();
    int frames = 0;
    rst = 1'b0; en = 1'b1; tens = 4'd1; ones = 4'd9; xiaoshu = 4'd5; point = 1'b1; led = 1'b0; lzb = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      frames += int'(frame);
      checks++;
      if ({an, seg, dp, frame} !== exp_pins) begin
        errors++; $display("FAIL basic m=%0d got=%h exp=%h", m, {an, seg, dp, frame}, exp_pins);
      end
      if (i == 4 || i == 14 || i == 24) begin
        checks++;
        if ({an, seg, dp} !== ((i == 4) ? 11'({3'b110, 7'h12, 1'b1}) :
                               (i == 14) ? 11'({3'b101, 7'h10, 1'b0}) : 11'({3'b011, 7'h79, 1'b1}))) begin
          errors++; $display("FAIL basic_glyph i=%0d got=%h", i, {an, seg, dp});
        end
      end
    end
    checks++;
    if (frames !== 3) begin errors++; $display("FAIL basic_frames got=%0d exp=3", frames); end
  endtask

  task automatic test_mid_frame();
    int frames = 0;
    bit changed = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      frames += int'(frame);
      checks++;
      if ({an, seg, dp, frame} !== exp_pins) begin
        errors++; $display("FAIL mid_frame m=%0d got=%h exp=%h", m, {an, seg, dp, frame}, exp_pins);
      end
      if (!changed && (m - 2) % 30 == 3) begin ones = 4'd3; changed = 1; end
    end
    checks++;
    if (frames !== 3) begin errors++; $display("FAIL mid_frame_frames got=%0d exp=3", frames); end
  endtask

  task automatic test_lzb();
    logic [3:0] tv [4] = '{4'd0, 4'd0, 4'd12, 4'd15};
    logic       lv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      tens = tv[k]; lzb = lv[k];
      for (int i = 0; i < 62; i++) begin
        tick();
        checks++;
        if ({an, seg, dp, frame} !== exp_pins) begin
          errors++; $display("FAIL lzb k=%0d m=%0d got=%h exp=%h", k, m, {an, seg, dp, frame}, exp_pins);
        end
      end
    end
    tens = 4'd1; lzb = 1'b0;
  endtask

  task automatic test_blink();
    int blanked;
    for (int ph = 0; ph < 2; ph++) begin
      led = (ph == 0);
      blanked = 0;
      for (int i = 0; i < 140; i++) begin
        tick();
        if (i >= 40 && seg === 7'h7F) blanked++;
        checks++;
        if ({an, seg, dp, frame} !== exp_pins) begin
          errors++; $display("FAIL blink led=%0d m=%0d got=%h exp=%h", led, m, {an, seg, dp, frame}, exp_pins);
        end
      end
      checks++;
      if (blanked !== ((ph == 0) ? 50 : 0)) begin
        errors++; $display("FAIL blink_count led=%0d got=%0d exp=%0d", led, blanked, (ph == 0) ? 50 : 0);
      end
    end
  endtask

  task automatic test_enable();
    while ((m - 2) % 30 != 15) tick();
    en = 1'b0;
    tick();
    checks++;
    if ({an, seg, dp, frame} !== 12'({3'b111, 7'h7F, 1'b1, 1'b0})) begin
      errors++; $display("FAIL en_off got=%h", {an, seg, dp, frame});
    end
    for (int i = 0; i < 5; i++) tick();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({an, frame} !== ((i == 0) ? 4'b1111 : (i < 3) ? 4'b1110 : 4'b1100)) begin
        errors++; $display("FAIL en_on i=%0d got an=%b frame=%b", i, an, frame);
      end
      checks++;
      if ({an, seg, dp, frame} !== exp_pins) begin
        errors++; $display("FAIL en_model i=%0d got=%h exp=%h", i, {an, seg, dp, frame}, exp_pins);
      end
    end
  endtask

  task automatic test_rst_mid();
    while ((m - 2) % 30 != 14) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({an, seg, dp, frame} !== 12'({3'b111, 7'h7F, 1'b1, 1'b0})) begin
      errors++; $display("FAIL rst_mid got=%h", {an, seg, dp, frame});
    end
    rst = 1'b0;
    for (int i = 0; i < 35; i++) begin
      tick();
      checks++;
      if ({an, seg, dp, frame} !== exp_pins) begin
        errors++; $display("FAIL rst_restart i=%0d got=%h exp=%h", i, {an, seg, dp, frame}, exp_pins);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      tens = 4'($urandom_range(15)); ones = 4'($urandom_range(15)); xiaoshu = 4'($urandom_range(15));
      point = 1'($urandom); led = 1'($urandom); lzb = 1'($urandom);
      if ($urandom_range(39) == 0) en = ~en;
      rst = ($urandom_range(299) == 0);
      tick();
      checks++;
      if ({an, seg, dp, frame} !== exp_pins) begin
        errors++; $display("FAIL random i=%0d m=%0d got=%h exp=%h", i, m, {an, seg, dp, frame}, exp_pins);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_frame();
    test_lzb();
    test_blink();
    test_enable();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Reader side of the timer's digit interface. Takes the BCD digits, decimal-point and blink flags produced by the countdown timer and drives a 3-digit, time-multiplexed, common-anode 7-segment display. Sits between the timer and the board pins. Owns scan timing, the anti-ghosting guard, per-frame snapshotting, BCD-to-segment decode, leading-zero blanking and blink gating.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
SCAN_HZ, 1000, per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ cycles per digit slot (DIV >= GUARD_CYC+2)
GUARD_CYC, 16, cycles at the start of each slot with all anodes off
BLINK_HZ, 2, blink rate; BLINK_DIV = CLK_HZ/BLINK_HZ cycles per full blink period

Ports:
clk      in   1  system clock
rst      in   1  synchronous reset, active-high
en       in   1  display enable
tens     in   4  BCD tens digit (leftmost, index 2)
ones     in   4  BCD ones digit (index 1)
xiaoshu  in   4  BCD tenths digit (rightmost, index 0)
point    in   1  decimal point request; lit on the ones digit
led      in   1  blink request for the whole display
lzb      in   1  leading-zero blank enable for the tens digit
an       out  3  digit select, active-low, one-hot-low or all-high
seg      out  7  segments {g,f,e,d,c,b,a}, active-low
dp       out  1  decimal point, active-low
frame    out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst=1 at a clk edge): an=3'b111, seg=7'h7F, dp=1, frame=0. Prescaler=0, digit index=0, blink counter=0, shadow digits=0.
- All outputs are registered. Pins reflect internal state one cycle later.
- Prescaler counts 0..DIV-1 and wraps. A slot ends at DIV-1. Digit index steps 0->1->2->0, one step per slot.
- Guard: when prescaler < GUARD_CYC, an=3'b111. Otherwise an has a single 0 at the current index. seg and dp update at the slot boundary, so they are stable before the anode turns on.
- Snapshot: tens, ones, xiaoshu, point, led and lzb are latched into shadow registers on the cycle the index wraps 2->0. The same happens on the first enabled cycle after reset or after en rises. frame pulses 1 on that same cycle. Input changes mid-frame never show until the next frame, so there is no tearing.
- Decode (shadow value): 0..9 use standard glyphs (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10). 10..14 show '-' (7'h3F). 15 shows blank (7'h7F).
- Leading-zero blank: lzb=1 and tens=0 -> tens slot seg=7'h7F. The anode still scans, so timing is unchanged.
- dp=0 only in the index-1 slot and only when the shadow point=1. All other slots have dp=1.
- Blink: a free-running counter runs 0..BLINK_DIV-1. The off-phase is the second half (counter >= BLINK_DIV/2). If the shadow led=1 during the off-phase, force seg=7'h7F and dp=1. Scanning continues.
- en=0: the prescaler and index are held at 0 and outputs go to their reset values next cycle. The blink counter keeps running. On en 0->1, snapshot and frame happen in the first enabled cycle, and the scan starts at index 0 with a guard.
- rst mid-frame: returns to reset values immediately. No partial slot is completed.
- Simultaneous en=0 and slot end: en wins, and no snapshot is taken.

Decomposition:
- Shared package: segment glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and the digit-index constants. The timer's preset path and future display blocks reuse these.
- One natural sub-module: bcd_to_seg, a purely combinational 4-bit -> 7-bit active-low decode that uses the package constants.
- Scan FSM, prescaler, guard, blink and snapshot stay in seg_scan_driver.

Test Plan:
(bench params: CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, GUARD_CYC=2, BLINK_HZ=10 -> BLINK_DIV=100)
1. Reset, then en=1 with tens=1, ones=9, xiaoshu=5, point=1 -> frame pulses once. Per 30-cycle frame, an shows 111,111,110x8 (seg=7'h12), then 111,111,101x8 (seg=7'h10, dp=0), then 111,111,011x8 (seg=7'h79).
2. Mid-frame, change ones 9->3 during slot 0 -> remaining slots of the frame still show 9 (7'h10). The next frame shows 3 (7'h30), and frame pulses every 30 cycles.
3. tens=0 with lzb=1 -> index-2 slot seg=7'h7F and an still 011. With lzb=0 -> seg=7'h40. tens=12 -> 7'h3F, tens=15 -> 7'h7F.
4. led=1 -> seg=7'h7F and dp=1 for 50 of every 100 cycles, normal glyphs in the other 50, and an scanning is unaffected. led=0 -> never blanked.
5. en 1->0 mid-slot -> an=111, seg=7'h7F, dp=1 one cycle later. en 0->1 -> frame pulse, then index 0 with a 2-cycle guard.
6. rst=1 for one cycle during slot 1 -> next cycle outputs are at reset values. After release, scanning restarts at index 0, with a snapshot taken when en=1.
